// File: rtl/sequence_collector.sv
// Collects generator samples into a show-ahead FIFO and keeps per-run count/sum/min/max.
// A run closes on the rising edge of in_done; statistics are published once the FIFO drains.
module sequence_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int SUM_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_value,
  input  logic                     in_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_value,
  output logic                     stats_valid,
  output logic        [CNT_W-1:0]  stat_count,
  output logic signed [SUM_W-1:0]  stat_sum,
  output logic signed [DATA_W-1:0] stat_min,
  output logic signed [DATA_W-1:0] stat_max,
  output logic                     overflow,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, REPORT} state_t;

  state_t                   state;
  logic                     in_done_q;
  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     done_rise;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     pop;
  logic                     start_run;
  logic                     accept;
  logic                     push_ok;
  logic signed [SUM_W-1:0]  sample_ext;

  assign done_rise  = in_done & ~in_done_q;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid  = ~fifo_empty;
  assign out_value  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign pop        = out_valid & out_ready;
  assign start_run  = (state == IDLE) & in_valid & ~in_done;
  assign accept     = start_run | ((state == COLLECT) & in_valid);
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign push_ok    = accept & (~fifo_full | pop);
  assign sample_ext = SUM_W'(in_value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= in_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_done_q   <= 1'b0;
      stats_valid <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      stat_count  <= '0;
      stat_sum    <= '0;
      stat_min    <= '0;
      stat_max    <= '0;
    end else begin
      in_done_q   <= in_done;
      stats_valid <= 1'b0;

      // Dropped samples still count toward the statistics.
      if (accept && !push_ok) overflow <= 1'b1;

      if (start_run) begin
        stat_count <= CNT_W'(1);
        stat_sum   <= sample_ext;
        stat_min   <= in_value;
        stat_max   <= in_value;
        overflow   <= 1'b0;
      end else if (accept) begin
        if (stat_count != '1) stat_count <= stat_count + CNT_W'(1);
        stat_sum <= stat_sum + sample_ext;
        if (in_value < stat_min) stat_min <= in_value;
        if (in_value > stat_max) stat_max <= in_value;
      end

      case (state)
        IDLE: begin
          if (start_run) begin
            state <= COLLECT;
            busy  <= 1'b1;
          end else if (done_rise) begin
            state       <= REPORT;
            stats_valid <= 1'b1;
            stat_count  <= '0;
            stat_sum    <= '0;
            stat_min    <= '0;
            stat_max    <= '0;
            overflow    <= 1'b0;
          end
        end
        COLLECT: begin
          if (done_rise) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            state       <= REPORT;
            busy        <= 1'b0;
            stats_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sequence_collector.sv
// Bench for sequence_collector: table of runs plus hand-written corner sequences,
// with a queue scoreboard checking the output stream.
module tb_sequence_collector;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int SUM_W  = 48;
  localparam int CNT_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_value = '0;
  logic                     in_done = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [DATA_W-1:0] out_value;
  logic                     stats_valid;
  logic        [CNT_W-1:0]  stat_count;
  logic signed [SUM_W-1:0]  stat_sum;
  logic signed [DATA_W-1:0] stat_min;
  logic signed [DATA_W-1:0] stat_max;
  logic                     overflow;
  logic                     busy;

  sequence_collector #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SUM_W(SUM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value), .in_done(in_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .stats_valid(stats_valid), .stat_count(stat_count), .stat_sum(stat_sum),
    .stat_min(stat_min), .stat_max(stat_max), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     start;
    int     step;
    int     n;
    bit     hold;
    int     exp_count;
    longint exp_sum;
    int     exp_min;
    int     exp_max;
    bit     exp_ovf;
  } run_t;

  int checks = 0;
  int passed = 0;
  logic signed [DATA_W-1:0] exp_q[$];
  int pops_seen = 0;
  bit saw_valid = 1'b0;
  bit hold_prev = 1'b0;
  logic signed [DATA_W-1:0] val_prev = '0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Scoreboard side: every accepted pop must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) saw_valid = 1'b1;
      if (hold_prev && out_valid) chk("head_stable", out_value, val_prev);
      if (out_valid && out_ready) begin
        chk("pop_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("out_value", out_value, exp_q.pop_front());
        pops_seen++;
      end
      hold_prev = out_valid && !out_ready;
      val_prev  = out_value;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic check_zero(string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_value"}, out_value, 0);
    chk({nm, "_stats_valid"}, stats_valid, 0);
    chk({nm, "_count"}, stat_count, 0);
    chk({nm, "_sum"}, stat_sum, 0);
    chk({nm, "_min"}, stat_min, 0);
    chk({nm, "_max"}, stat_max, 0);
    chk({nm, "_overflow"}, overflow, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic finish_run(string nm, int exp_count, longint exp_sum, int exp_min,
                            int exp_max, bit exp_ovf, int exp_pops, int exp_lat);
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!stats_valid && cyc < 100);
    chk({nm, "_stats_valid"}, stats_valid, 1);
    if (exp_lat > 0) chk({nm, "_latency"}, cyc, exp_lat);
    chk({nm, "_count"}, stat_count, exp_count);
    chk({nm, "_sum"}, stat_sum, exp_sum);
    chk({nm, "_min"}, stat_min, exp_min);
    chk({nm, "_max"}, stat_max, exp_max);
    chk({nm, "_overflow"}, overflow, exp_ovf);
    chk({nm, "_pops"}, pops_seen, exp_pops);
    chk({nm, "_queue_left"}, exp_q.size(), 0);
    $display("run %s: count=%0d sum=%0d min=%0d max=%0d overflow=%0d pops=%0d",
             nm, stat_count, stat_sum, stat_min, stat_max, overflow, pops_seen);
    in_done = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_pulse_one_cycle"}, stats_valid, 0);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_count_held"}, stat_count, exp_count);
  endtask

  task automatic run_run(run_t r, string nm);
    int kept;
    kept = r.hold ? ((r.n < DEPTH) ? r.n : DEPTH) : r.n;
    pops_seen = 0;
    saw_valid = 1'b0;
    out_ready = !r.hold;
    for (int i = 0; i < r.n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_value = r.start + i * r.step;
      if (!r.hold || i < DEPTH) exp_q.push_back(in_value);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_done   = 1'b1;
    out_ready = 1'b1;
    if (r.n > 0) chk({nm, "_busy"}, busy, 1);
    finish_run(nm, r.exp_count, r.exp_sum, r.exp_min, r.exp_max, r.exp_ovf, kept,
               (r.n == 0) ? 1 : 0);
    if (r.n == 0) chk({nm, "_no_out_valid"}, saw_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    run_t runs[4];
    run_t rerun;
    runs[0] = '{10, 5, 5, 0, 5, 100, 10, 30, 0};
    runs[1] = '{0, -3, 4, 0, 4, -18, -9, 0, 0};
    runs[2] = '{1, 1, 10, 1, 10, 55, 1, 10, 1};
    runs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    #12;
    check_zero("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_run(runs[i], $sformatf("table%0d", i));

    // Full FIFO with a pop in the same cycle as the ninth push: nothing dropped.
    pops_seen = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_value = i;
      exp_q.push_back(in_value);
    end
    @(posedge clk); #1;
    in_value  = DEPTH + 1;
    out_ready = 1'b1;
    exp_q.push_back(in_value);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_done  = 1'b1;
    finish_run("full_pop", 9, 45, 1, 9, 0, 9, 0);

    // Sample coincident with done is kept; a sample during drain is ignored.
    pops_seen = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_value = 4;
    exp_q.push_back(in_value);
    @(posedge clk); #1;
    in_value = 6;
    in_done  = 1'b1;
    exp_q.push_back(in_value);
    @(posedge clk); #1;
    in_value = 99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_run("done_same_cycle", 2, 10, 4, 6, 0, 2, 0);

    // Reset in the middle of a run with data still buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_value = 20 + i;
    end
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    rerun = '{7, 1, 2, 0, 2, 15, 7, 8, 0};
    run_run(rerun, "after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sequence_collector.md
Name: sequence_collector

Overview:
- Downstream consumer of the sequence generator; sits directly after it.
- Takes each generated signed value and buffers it in a show-ahead FIFO for a valid/ready sink.
- Keeps per-run statistics: count, sum, min and max.
- Closes the run on the generator's done rising edge, drains the FIFO, then publishes the statistics with a one-cycle strobe.

Parameters:
- DATA_W, 32: width of signed sample values.
- DEPTH, 8: FIFO entries; must be a power of 2, ≥2.
- SUM_W, 48: width of signed running sum; must be ≥ DATA_W.
- CNT_W, 16: width of sample counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe; high for one cycle per new generator value.
- in_value  in  DATA_W  signed sample (generator sequence_value).
- in_done  in  1  generator done level.
- out_valid  out  1  FIFO head valid (= not empty).
- out_ready  in  1  sink accepts head when out_valid & out_ready.
- out_value  out  DATA_W  FIFO head, show-ahead.
- stats_valid  out  1  one-cycle pulse: statistics final.
- stat_count  out  CNT_W  samples accepted in run; saturates at all-ones.
- stat_sum  out  SUM_W  signed sum of accepted samples; sign-extended, wraps modulo 2^SUM_W.
- stat_min  out  DATA_W  signed minimum.
- stat_max  out  DATA_W  signed maximum.
- overflow  out  1  sticky: at least one sample dropped because the FIFO was full this run.
- busy  out  1  high in COLLECT or DRAIN.

Behaviour:
- Reset (async, any time, including mid-run):
  - state = IDLE; FIFO emptied (out_valid = 0, out_value = 0).
  - stats_valid, stat_count, stat_sum, stat_min, stat_max, overflow and busy all = 0.
  - Done-edge detector register cleared to 0.
- done_rise = in_done & ~in_done_q, where in_done_q is in_done registered.
- IDLE:
  - in_valid & ~in_done: clear count, sum and overflow; accept the sample as the first of the run; min = max = sample; go to COLLECT.
  - in_valid while in_done high: ignored.
  - done_rise with no in_valid: empty run; go directly to REPORT with count = 0, sum = 0, min = max = 0.
- COLLECT, each in_valid cycle:
  - count += 1, saturating.
  - sum += sign_extend(in_value).
  - min/max updated with signed compare.
  - Push sample to FIFO.
- On done_rise: go to DRAIN. An in_valid in the same cycle is accepted first.
- DRAIN:
  - in_valid ignored; stay until FIFO empty, then go to REPORT.
  - FIFO empty on entry: REPORT on the next cycle.
- REPORT: stats_valid = 1 for exactly one cycle, then IDLE. stat_* and overflow hold their values until the next run starts.
- Statistics registers update on the cycle after acceptance and are only guaranteed final when stats_valid = 1.
- FIFO:
  - Push when the sample is accepted.
  - If full with no pop in the same cycle: drop the sample and set overflow. Count, sum, min and max still include the dropped sample.
  - Full with a simultaneous pop: push succeeds, no drop.
  - Pop when out_valid & out_ready.
  - Empty with a simultaneous push: out_valid rises the next cycle; no same-cycle bypass.
  - Latency: accepted at edge N means visible on out_value after edge N+1 at earliest.
  - out_value is stable while out_valid & ~out_ready.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

Test Plan:
- Basic run: start 10, step 5, range_max 30 (samples 10, 15, 20, 25, 30), done rises, out_ready = 1 → out stream 10, 15, 20, 25, 30; one stats_valid with count 5, sum 100, min 10, max 30, overflow 0.
- Negative step: samples 0, -3, -6, -9, out_ready = 1 → sum -18, min -9, max 0; stat_sum sign-extended (-18 in 48 bits).
- Backpressure: 10 samples 1..10, out_ready = 0 until done rises, DEPTH 8 → out stream 1..8; overflow 1; count 10, sum 55; stats_valid only after the 8th pop.
- Full with simultaneous pop: FIFO holds 8 entries, out_ready = 1 on the same cycle as a new push → no drop, overflow 0.
- Empty run: done rises with no in_valid → stats_valid after 1 cycle; all stats 0; out_valid never asserted.
- Reset mid-run: assert rst after 3 samples → same cycle all outputs 0, FIFO empty; next run (samples 7, 8) reports count 2, sum 15, unaffected by the aborted run.
